// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_DIVISOR = 12_500_000;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // A pattern shorter than two bits is meaningless; longer than the shift register cannot be compared.
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= 2) && (len <= max_len);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Bit-sample tick generator: one tick every DIVISOR enabled cycles, phase held while disabled.
module tick_gen
  import seq_det_pkg::*;
#(
  parameter int DIVISOR = DEF_DIVISOR
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int TW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [TW-1:0] LAST = TW'(DIVISOR - 1);

  logic [TW-1:0] cnt;

  // Count 0..DIVISOR-1 while enabled; hold the phase when disabled so a pause resumes mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector with run/hold control and a saturating match counter.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int DIVISOR = DEF_DIVISOR,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int LEN_W  = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               count_clr,
  input  logic               inp_stream,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy
);

  localparam int BITS_W = $clog2(MAX_LEN + 1);
  localparam logic [BITS_W-1:0] BITS_FULL = BITS_W'(MAX_LEN);

  state_t state, state_nxt;

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               loaded_q;
  logic [MAX_LEN-1:0] shreg_q;
  logic [BITS_W-1:0]  bits_q;
  logic               cfg_err_q;
  logic               match_pulse_q;
  logic [CNT_W-1:0]   count_q;

  logic               cfg_accept;
  logic               cfg_legal;
  logic               start_run;
  logic               tick;
  logic [MAX_LEN-1:0] shreg_shifted;
  logic [BITS_W-1:0]  bits_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               match_now;

  assign cfg_accept = cfg_valid && cfg_ready;
  assign cfg_legal  = len_legal(int'(cfg_len), MAX_LEN);
  assign start_run  = (state == IDLE) && start && !stop && loaded_q;

  tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (state == RUN),
    .clr (start_run),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and status outputs; stop always wins over start and pause.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (start && loaded_q && !stop) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop)       state_nxt = IDLE;
        else if (pause) state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (stop)        state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift-and-compare datapath: window mask for the active length and the match decision for this tick.
  always_comb begin
    shreg_shifted = {shreg_q[MAX_LEN-2:0], inp_stream};
    bits_inc      = (bits_q == BITS_FULL) ? bits_q : bits_q + 1'b1;
    len_mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match_now = tick && (int'(bits_inc) >= int'(len_q)) &&
                (((shreg_shifted ^ pattern_q) & len_mask) == '0);
  end

  // Configuration capture; an illegal length leaves the stored setup untouched and flags an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      loaded_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_accept && !cfg_legal;
      if (cfg_accept && cfg_legal) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        loaded_q  <= 1'b1;
      end
    end
  end

  // Shift register and bit history; a non-overlapping match starts the window afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      bits_q  <= '0;
    end else if (start_run) begin
      shreg_q <= '0;
      bits_q  <= '0;
    end else if (tick) begin
      if (match_now && !overlap_q) begin
        shreg_q <= '0;
        bits_q  <= '0;
      end else begin
        shreg_q <= shreg_shifted;
        bits_q  <= bits_inc;
      end
    end
  end

  // Match pulse lands the cycle after its tick; the counter follows the pulse and clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_pulse_q <= 1'b0;
      count_q       <= '0;
    end else begin
      match_pulse_q <= match_now;
      if (count_clr)                         count_q <= '0;
      else if (match_pulse_q && count_q != '1) count_q <= count_q + 1'b1;
    end
  end

  assign cfg_err     = cfg_err_q;
  assign match_pulse = match_pulse_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, scoreboard-driven bench for seq_detect_ctrl at a fast sample rate.
module tb_seq_detect_ctrl;

  localparam int DIV   = 4;
  localparam int ML    = 8;
  localparam int CW    = 16;
  localparam int LEN_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [ML-1:0]   cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic            cfg_overlap = 1'b0;
  logic            cfg_err;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic            pause = 1'b0;
  logic            count_clr = 1'b0;
  logic            inp_stream = 1'b0;
  logic            match_pulse;
  logic [CW-1:0]   match_count;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mdl_shreg = '0;
  int          mdl_bits = 0;
  logic [7:0]  mdl_pat = '0;
  int          mdl_len = 0;
  logic        mdl_ovl = 1'b0;
  logic        mdl_loaded = 1'b0;
  logic [15:0] mdl_count = '0;
  logic        exp_q[$];

  seq_detect_ctrl #(
    .MAX_LEN(ML),
    .DIVISOR(DIV),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_err    (cfg_err),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .count_clr  (count_clr),
    .inp_stream (inp_stream),
    .match_pulse(match_pulse),
    .match_count(match_count),
    .busy       (busy)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Model one sampled bit: returns whether the detector should report a match.
  function automatic logic model_tick(input logic b);
    logic [7:0] mask;
    logic       hit;
    mdl_shreg = {mdl_shreg[6:0], b};
    if (mdl_bits < 8) mdl_bits++;
    mask = 8'hFF >> (8 - mdl_len);
    hit = (mdl_bits >= mdl_len) && ((mdl_shreg & mask) == (mdl_pat & mask));
    if (hit && !mdl_ovl) begin
      mdl_shreg = '0;
      mdl_bits  = 0;
    end
    if (hit && mdl_count != 16'hFFFF) mdl_count = mdl_count + 16'd1;
    return hit;
  endfunction

  task automatic clk_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one serial bit for a full sample period and compare the pulse on every cycle.
  task automatic apply_stimulus(input logic b);
    inp_stream = b;
    exp_q.push_back(model_tick(b));
    for (int i = 0; i < DIV; i++) begin
      clk_step();
      if (i == DIV - 1) check_output("match_pulse_tick", 32'(match_pulse), 32'(exp_q.pop_front()));
      else              check_output("match_pulse_quiet", 32'(match_pulse), 32'd0);
    end
  endtask

  task automatic apply_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic exp_err);
    cfg_valid   = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    clk_step();
    cfg_valid = 1'b0;
    check_output("cfg_err_pulse", 32'(cfg_err), 32'(exp_err));
    clk_step();
    check_output("cfg_err_clear", 32'(cfg_err), 32'd0);
    if (!exp_err) begin
      mdl_pat    = pat;
      mdl_len    = int'(len);
      mdl_ovl    = ovl;
      mdl_loaded = 1'b1;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    clk_step();
    start = 1'b0;
    mdl_shreg = '0;
    mdl_bits  = 0;
    check_output("busy_after_start", 32'(busy), 32'(mdl_loaded));
  endtask

  task automatic stop_run();
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
    check_output("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic run_stream(input logic [9:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) apply_stimulus(bits[i]);
  endtask

  initial begin
    logic [9:0] s7;
    logic [9:0] s10;
    s7  = 10'b0001001001;
    s10 = 10'b1001001001;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clk_step();
    check_output("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_pulse", 32'(match_pulse), 32'd0);
    check_output("reset_count", 32'(match_count), 32'd0);
    check_output("reset_cfg_err", 32'(cfg_err), 32'd0);

    $display("[TB] start without configuration, illegal lengths");
    start_run();
    apply_cfg(8'h09, 4'd1, 1'b0, 1'b1);
    start_run();
    apply_cfg(8'h09, 4'd4, 1'b0, 1'b0);
    apply_cfg(8'hFF, 4'd9, 1'b1, 1'b1);

    $display("[TB] non-overlap stream");
    start_run();
    run_stream(s7, 7);
    stop_run();
    check_output("count_nonoverlap", 32'(match_count), 32'(mdl_count));

    $display("[TB] overlap stream");
    count_clr = 1'b1;
    clk_step();
    count_clr = 1'b0;
    mdl_count = '0;
    check_output("count_clr_idle", 32'(match_count), 32'd0);
    apply_cfg(8'h09, 4'd4, 1'b1, 1'b0);
    start_run();
    run_stream(s7, 7);
    stop_run();
    check_output("count_overlap", 32'(match_count), 32'd2);

    $display("[TB] pause mid-bit");
    apply_cfg(8'h09, 4'd4, 1'b0, 1'b0);
    start_run();
    run_stream(10'b0000000100, 3);
    inp_stream = 1'b1;
    exp_q.push_back(model_tick(1'b1));
    repeat (2) begin
      clk_step();
      check_output("pause_pre", 32'(match_pulse), 32'd0);
    end
    pause = 1'b1;
    repeat (10) begin
      clk_step();
      check_output("pause_hold_pulse", 32'(match_pulse), 32'd0);
      check_output("pause_hold_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    clk_step();
    check_output("pause_resume", 32'(match_pulse), 32'd0);
    clk_step();
    check_output("pause_phase_tick", 32'(match_pulse), 32'(exp_q.pop_front()));

    $display("[TB] stop and start together");
    stop  = 1'b1;
    start = 1'b1;
    clk_step();
    check_output("stopstart_busy", 32'(busy), 32'd0);
    check_output("stopstart_ready", 32'(cfg_ready), 32'd1);
    clk_step();
    check_output("stopstart_idle_busy", 32'(busy), 32'd0);
    stop  = 1'b0;
    start = 1'b0;
    check_output("count_after_pause", 32'(match_count), 32'(mdl_count));

    $display("[TB] saturation");
    apply_cfg(8'h09, 4'd4, 1'b1, 1'b0);
    force dut.count_q = 16'hFFFE;
    clk_step();
    release dut.count_q;
    mdl_count = 16'hFFFE;
    check_output("count_preset", 32'(match_count), 32'hFFFE);
    start_run();
    run_stream(s10, 10);
    clk_step();
    check_output("count_saturated", 32'(match_count), 32'(mdl_count));
    check_output("count_all_ones", 32'(match_count), 32'hFFFF);
    stop_run();

    $display("[TB] reset during matching tick");
    start_run();
    run_stream(10'b0000000100, 3);
    inp_stream = 1'b1;
    for (int i = 0; i < DIV - 1; i++) begin
      clk_step();
      check_output("rst_pre_pulse", 32'(match_pulse), 32'd0);
    end
    rst = 1'b1;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_count", 32'(match_count), 32'd0);
    check_output("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("rst_no_pulse", 32'(match_pulse), 32'd0);
    rst = 1'b0;
    mdl_loaded = 1'b0;
    mdl_count  = '0;
    clk_step();
    check_output("rst_release_ready", 32'(cfg_ready), 32'd1);
    check_output("rst_release_pulse", 32'(match_pulse), 32'd0);
    start_run();

    $display("[TB] count_clr coincident with match");
    apply_cfg(8'h09, 4'd4, 1'b0, 1'b0);
    start_run();
    run_stream(10'b0000001001, 4);
    count_clr = 1'b1;
    clk_step();
    count_clr = 1'b0;
    mdl_count = '0;
    check_output("count_clr_priority", 32'(match_count), 32'(mdl_count));
    clk_step();
    check_output("count_clr_hold", 32'(match_count), 32'd0);
    stop_run();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter DIVISOR, default 12_500_000: clk cycles per bit-sample tick (25 MHz to 2 Hz).
REQ-003 SHALL have parameter CNT_W, default 16: match counter width.
REQ-004 SHALL have port clk, input, 1: the only clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port cfg_valid, input, 1: configuration offered.
REQ-007 SHALL have port cfg_ready, output, 1: configuration accepted when high with cfg_valid.
REQ-008 SHALL have port cfg_pattern, input, MAX_LEN: pattern bits, with the LSB being the most recent bit.
REQ-009 SHALL have port cfg_len, input, $clog2(MAX_LEN)+1: pattern length.
REQ-010 SHALL have port cfg_overlap, input, 1: 1 = overlapping detection.
REQ-011 SHALL have port cfg_err, output, 1: one-cycle pulse that flags a rejected configuration.
REQ-012 SHALL have port start, input, 1: level, sampled each cycle.
REQ-013 SHALL have port stop, input, 1: level, sampled each cycle.
REQ-014 SHALL have port pause, input, 1: level, freezes sampling while high.
REQ-015 SHALL have port count_clr, input, 1: synchronous clear of match_count.
REQ-016 SHALL have port inp_stream, input, 1: serial data, already synchronous to clk.
REQ-017 SHALL have port match_pulse, output, 1: one-cycle pulse per detected match.
REQ-018 SHALL have port match_count, output, CNT_W: saturating match total.
REQ-019 SHALL have port busy, output, 1: high in RUN or HOLD.

Function
REQ-020 SHALL implement an FSM with states IDLE, RUN and HOLD, and SHALL reset to IDLE.
REQ-021 SHALL drive cfg_ready = (state==IDLE); the handshake completes on cfg_valid&&cfg_ready in one cycle.
REQ-022 SHALL, for an accepted cfg_len outside 2..MAX_LEN, leave the stored configuration unchanged and pulse cfg_err on the next cycle.
REQ-023 SHALL mark the configuration loaded after the first legal accept; start SHALL be ignored while the configuration is not loaded.
REQ-024 SHALL transition IDLE->RUN on start when loaded, clearing the tick counter, the shift register and the bits_seen count.
REQ-025 SHALL transition RUN->HOLD on pause and HOLD->RUN on pause deasserted; the tick counter SHALL hold its value in HOLD.
REQ-026 SHALL transition RUN or HOLD->IDLE on stop; stop SHALL beat start and pause in the same cycle; match_count SHALL be kept.
REQ-027 SHALL, in RUN, count a tick counter from 0 to DIVISOR-1 and wrap; a tick SHALL occur on the cycle the counter equals DIVISOR-1.
REQ-028 SHALL, on a tick, shift inp_stream into the LSB of a MAX_LEN shift register and increment bits_seen, saturating at MAX_LEN.
REQ-029 SHALL declare a match when bits_seen (after the shift) >= cfg_len and the low cfg_len bits equal the low cfg_len bits of the pattern.
REQ-030 SHALL assert match_pulse exactly one cycle after the tick cycle that produced the match.
REQ-031 SHALL, in non-overlap mode, clear the shift register and bits_seen on a match, so the next match needs cfg_len new bits.
REQ-032 SHALL, in overlap mode, not clear state on a match.
REQ-033 SHALL increment match_count on each match_pulse and saturate it at all-ones.
REQ-034 SHALL give count_clr priority over a simultaneous increment, leaving match_count at 0.
REQ-035 SHALL sample no bits while in IDLE or HOLD.

Reset
REQ-036 SHALL, on rst, immediately set state=IDLE, clear the stored configuration and the loaded flag, and zero the counters and shift register.
REQ-037 SHALL, on rst, drive match_pulse=0, cfg_err=0, match_count=0 and busy=0; cfg_ready SHALL be 1 on the first cycle after reset release.
REQ-038 SHALL, on rst during RUN, produce no match_pulse from the in-flight tick.

Structure
REQ-039 SHALL take the state enum (IDLE/RUN/HOLD) and the default MAX_LEN, DIVISOR and CNT_W from the shared package seq_det_pkg.
REQ-040 SHALL instantiate the tick generator as sub-module tick_gen, with inputs clk, rst, en and clr and output tick.
REQ-041 SHALL use no derived clocks; all flops SHALL be on clk.

Verification (DIVISOR=4 for simulation)
REQ-042 SHALL verify: cfg 4'b1001, len 4, overlap 0, start; stream 1,0,0,1,0,0,1 -> one match_pulse (after the 4th bit), match_count=1.
REQ-043 SHALL verify: same stream with overlap 1 -> pulses after the 4th and 7th bits, match_count=2.
REQ-044 SHALL verify: cfg_len=1 or 9 -> cfg_err pulse, old configuration retained; start before any legal configuration -> stays IDLE.
REQ-045 SHALL verify: pause for 10 cycles mid-stream -> no bits sampled, tick phase resumes; stop+start in the same cycle -> IDLE.
REQ-046 SHALL verify: match_count preset to near all-ones by forcing -> saturates at 16'hFFFF; count_clr coincident with a match -> 0.
REQ-047 SHALL verify: rst asserted in the cycle of a matching tick -> no match_pulse, all outputs at reset values, cfg_ready=1 after release.
